// File: rtl/uart_pkg.sv
// Shared types and constants for the sample-to-UART transmit path.
// The byte serialiser and the 16-bit sample wrapper both import this.
package uart_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int SAMPLE_W             = 16;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  function automatic logic [UART_BYTE_W-1:0] sample_byte(
    input logic [SAMPLE_W-1:0] sample,
    input logic                upper
  );
    return upper ? sample[SAMPLE_W-1 -: UART_BYTE_W] : sample[UART_BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: START/DATA/STOP state machine and baud counter.
// byte_ready is also high on the last stop-bit cycle so bytes can chain with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_BYTE_W-1:0] byte_data,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   byte_done,
  output logic                   busy,
  output logic                   tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_BYTE_W-1:0] shreg;
  logic                   tx_q;
  logic                   tick;
  logic                   accept;

  assign tick   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign accept = byte_valid && byte_ready;
  assign busy   = (state_q != IDLE);
  assign tx     = tx_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    byte_ready = 1'b0;
    byte_done  = 1'b0;
    case (state_q)
      IDLE: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bit_cnt == 3'd7) state_d = STOP;
      STOP: begin
        if (tick) begin
          byte_done  = 1'b1;
          byte_ready = 1'b1;
          state_d    = byte_valid ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      // Held at zero in IDLE so bit timing starts exactly at the accepting edge.
      if (state_q == IDLE || tick) baud_cnt <= '0;
      else                         baud_cnt <= baud_cnt + 1'b1;

      case (state_q)
        IDLE, STOP: begin
          if (accept) begin
            shreg <= byte_data;
            tx_q  <= 1'b0;
          end else if (state_q == IDLE || tick) begin
            tx_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
              tx_q <= 1'b1;
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: tx_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uart_sample_tx.sv
// Sends one 16-bit sample per handshake as two back-to-back 8N1 frames.
// Holds the sample, sequences the two bytes and raises frame_done after the second stop bit.
module uart_sample_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MSB_FIRST    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx_data,
  output logic        busy,
  output logic        frame_done
);

  logic [SAMPLE_W-1:0]    hold_q;
  logic                   bidx_q;
  logic                   frame_done_q;
  logic [UART_BYTE_W-1:0] byte_data;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   byte_done;
  logic                   byte_busy;
  logic                   first_go;
  logic                   second_go;

  assign in_ready   = !byte_busy;
  assign busy       = byte_busy;
  assign frame_done = frame_done_q;

  // byte_ready while busy only happens on the final stop-bit cycle of a byte.
  assign first_go   = in_valid && in_ready;
  assign second_go  = byte_busy && byte_ready && !bidx_q;
  assign byte_valid = first_go || second_go;
  assign byte_data  = first_go ? sample_byte(in_data, MSB_FIRST != 0)
                               : sample_byte(hold_q, MSB_FIRST == 0);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk       (clk),
    .reset     (reset),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .busy      (byte_busy),
    .tx        (tx_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      bidx_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= byte_done && bidx_q;
      if (first_go) begin
        hold_q <= in_data;
        bidx_q <= 1'b0;
      end else if (second_go) begin
        bidx_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_tx.sv
// Directed bench for uart_sample_tx at CLKS_PER_BIT=4, with an MSB_FIRST=1 and an MSB_FIRST=0 instance.
// Expected line levels and decoded bytes are hand-derived from the samples sent.
module tb_uart_sample_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx_data;
  logic        busy;
  logic        frame_done;

  logic [15:0] l_data;
  logic        l_valid;
  logic        l_ready;
  logic        l_tx;
  logic        l_busy;
  logic        l_done;

  int total = 0;
  int bad   = 0;

  uart_sample_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  uart_sample_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(0)) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .in_data   (l_data),
    .in_valid  (l_valid),
    .in_ready  (l_ready),
    .tx_data   (l_tx),
    .busy      (l_busy),
    .frame_done(l_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accepting edge; samples each bit mid-way, returns 80 cycles later.
  task automatic capture(input bit lsb, output logic [19:0] line);
    line = '0;
    for (int c = 0; c < 20 * CPB; c++) begin
      if (c % CPB == CPB / 2) line[c / CPB] = lsb ? l_tx : tx_data;
      tick();
    end
  endtask

  task automatic check_frames(input string tag, input logic [19:0] line,
                              input logic [7:0] b0, input logic [7:0] b1);
    check({tag, "_start0"}, line[0], 1'b0);
    check({tag, "_byte0"},  line[8:1], b0);
    check({tag, "_stop0"},  line[9], 1'b1);
    check({tag, "_start1"}, line[10], 1'b0);
    check({tag, "_byte1"},  line[18:11], b1);
    check({tag, "_stop1"},  line[19], 1'b1);
  endtask

  initial begin
    logic [19:0] exp_line;
    logic [19:0] line;
    int          gap;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    l_valid  = 1'b0;
    l_data   = '0;

    // 1. reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_tx_%0d", i),      tx_data,    1'b1);
      check($sformatf("rst_ready_%0d", i),   in_ready,   1'b1);
      check($sformatf("rst_busy_%0d", i),    busy,       1'b0);
      check($sformatf("rst_done_%0d", i),    frame_done, 1'b0);
      check($sformatf("rst_l_tx_%0d", i),    l_tx,       1'b1);
      check($sformatf("rst_l_ready_%0d", i), l_ready,    1'b1);
    end
    reset = 1'b0;
    tick();

    // 2. single sample A53C, line level checked every cycle
    exp_line = 20'b1001_1110_0011_0100_1010;  // index k = bit time k
    check("a53c_ready_pre", in_ready, 1'b1);
    in_data  = 16'hA53C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 16'h0000;
    check("a53c_ready_c0", in_ready, 1'b0);
    check("a53c_busy_c0",  busy,     1'b1);
    for (int c = 0; c < 20 * CPB; c++) begin
      check($sformatf("a53c_tx_c%0d", c), tx_data, exp_line[c / CPB]);
      if (frame_done) check($sformatf("a53c_early_done_c%0d", c), frame_done, 1'b0);
      tick();
    end
    check("a53c_done_c80",  frame_done, 1'b1);
    check("a53c_ready_c80", in_ready,   1'b1);
    check("a53c_busy_c80",  busy,       1'b0);
    check("a53c_tx_c80",    tx_data,    1'b1);
    tick();
    check("a53c_done_c81",  frame_done, 1'b0);

    // 3. low byte first, 00FF
    l_data  = 16'h00FF;
    l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    capture(1'b1, line);
    check_frames("lsb00ff", line, 8'hFF, 8'h00);
    check("lsb00ff_done", l_done, 1'b1);
    tick();

    // 4. back-to-back with in_valid held; in_data changes mid-transfer
    in_data  = 16'h0001;
    in_valid = 1'b1;
    tick();
    in_data  = 16'h8000;
    capture(1'b0, line);
    check_frames("b2b_0001", line, 8'h00, 8'h01);
    check("b2b_idle_tx", tx_data, 1'b1);
    gap = 20 * CPB;
    while (!in_ready && gap < 200) begin
      tick();
      gap++;
    end
    tick();
    gap++;
    in_valid = 1'b0;
    check("b2b_gap", gap, 20 * CPB + 1);
    check("b2b_busy2", busy, 1'b1);
    capture(1'b0, line);
    check_frames("b2b_8000", line, 8'h80, 8'h00);
    tick();

    // 5. reset mid-frame at cycle 30 of FFFF, then a clean 1234
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check("abort_tx",    tx_data,    1'b1);
    check("abort_ready", in_ready,   1'b1);
    check("abort_busy",  busy,       1'b0);
    check("abort_done",  frame_done, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("post_abort_ready", in_ready, 1'b1);
    check("post_abort_tx",    tx_data,  1'b1);
    in_data  = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    capture(1'b0, line);
    check_frames("s1234", line, 8'h12, 8'h34);
    check("s1234_done", frame_done, 1'b1);
    tick();

    // 6. stall: no valid for 50 cycles after reset
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    in_data = 16'hDEAD;
    for (int c = 0; c < 50; c++) begin
      tick();
      check($sformatf("stall_tx_%0d", c),   tx_data,    1'b1);
      check($sformatf("stall_done_%0d", c), frame_done, 1'b0);
      check($sformatf("stall_busy_%0d", c), busy,       1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
